// File: rtl/dcache_req_arbiter_if.sv
// Bundle between the two EXM lanes, the arbiter and the data cache port.
// The arbiter binds to slave; the lanes plus cache side (or a bench) bind to master.
interface dcache_req_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              l0_valid;
    logic              l0_op;
    logic [ADDR_W-1:0] l0_addr;
    logic              l0_uncached;
    logic [3:0]        l0_awstrb;
    logic [31:0]       l0_wdata;
    logic              l0_cacop_en;
    logic [1:0]        l0_cacop_code;
    logic [ADDR_W-1:0] l0_cacop_addr;
    logic              l0_ready;
    logic              l0_rvalid;
    logic [31:0]       l0_rdata;

    logic              l1_valid;
    logic              l1_op;
    logic [ADDR_W-1:0] l1_addr;
    logic              l1_uncached;
    logic [3:0]        l1_awstrb;
    logic [31:0]       l1_wdata;
    logic              l1_cacop_en;
    logic [1:0]        l1_cacop_code;
    logic [ADDR_W-1:0] l1_cacop_addr;
    logic              l1_ready;
    logic              l1_rvalid;
    logic [31:0]       l1_rdata;

    logic              dc_valid;
    logic              dc_op;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_uncached;
    logic [3:0]        dc_awstrb;
    logic [31:0]       dc_wdata;
    logic              dc_cacop_en;
    logic [1:0]        dc_cacop_code;
    logic [ADDR_W-1:0] dc_cacop_addr;
    logic              dc_ready;
    logic              dc_rvalid;
    logic [31:0]       dc_rdata;

    logic              resp_err;

    modport slave (
        input  l0_valid, l0_op, l0_addr, l0_uncached, l0_awstrb, l0_wdata,
               l0_cacop_en, l0_cacop_code, l0_cacop_addr,
        output l0_ready, l0_rvalid, l0_rdata,
        input  l1_valid, l1_op, l1_addr, l1_uncached, l1_awstrb, l1_wdata,
               l1_cacop_en, l1_cacop_code, l1_cacop_addr,
        output l1_ready, l1_rvalid, l1_rdata,
        output dc_valid, dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata,
               dc_cacop_en, dc_cacop_code, dc_cacop_addr,
        input  dc_ready, dc_rvalid, dc_rdata,
        output resp_err
    );

    modport master (
        output l0_valid, l0_op, l0_addr, l0_uncached, l0_awstrb, l0_wdata,
               l0_cacop_en, l0_cacop_code, l0_cacop_addr,
        input  l0_ready, l0_rvalid, l0_rdata,
        output l1_valid, l1_op, l1_addr, l1_uncached, l1_awstrb, l1_wdata,
               l1_cacop_en, l1_cacop_code, l1_cacop_addr,
        input  l1_ready, l1_rvalid, l1_rdata,
        input  dc_valid, dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata,
               dc_cacop_en, dc_cacop_code, dc_cacop_addr,
        output dc_ready, dc_rvalid, dc_rdata,
        input  resp_err
    );
endinterface

// File: rtl/dcache_req_arbiter.sv
// Two-lane arbiter for the shared dcache port: one registered request slot,
// fixed lane0 priority, and an in-order tag queue that routes read data back.
module dcache_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    dcache_req_arbiter_if.slave bus
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic              uncached;
        logic [3:0]        awstrb;
        logic [31:0]       wdata;
        logic              cacop_en;
        logic [1:0]        cacop_code;
        logic [ADDR_W-1:0] cacop_addr;
    } req_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_HELD
    } slot_state_t;

    slot_state_t state_reg, state_next;
    req_t        slot_reg, slot_next;
    logic        slot_lane_reg, slot_lane_next;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             resp_err_reg;

    req_t l0_req, l1_req;
    logic l0_is_read, l1_is_read, slot_is_read;
    logic slot_held, slot_free, push, pop, q_empty, q_has_room;
    logic can_issue, l0_grant, l1_grant;
    logic [CNT_W-1:0] reserved;

    logic [MAX_OUTSTANDING-1:0] tag_lane, tag_killed;
    logic head_lane, deliver;

    assign l0_req = '{op: bus.l0_op, addr: bus.l0_addr, uncached: bus.l0_uncached,
                      awstrb: bus.l0_awstrb, wdata: bus.l0_wdata, cacop_en: bus.l0_cacop_en,
                      cacop_code: bus.l0_cacop_code, cacop_addr: bus.l0_cacop_addr};
    assign l1_req = '{op: bus.l1_op, addr: bus.l1_addr, uncached: bus.l1_uncached,
                      awstrb: bus.l1_awstrb, wdata: bus.l1_wdata, cacop_en: bus.l1_cacop_en,
                      cacop_code: bus.l1_cacop_code, cacop_addr: bus.l1_cacop_addr};

    assign l0_is_read   = !bus.l0_op && !bus.l0_cacop_en;
    assign l1_is_read   = !bus.l1_op && !bus.l1_cacop_en;
    assign slot_is_read = !slot_reg.op && !slot_reg.cacop_en;

    assign slot_held = (state_reg == SLOT_HELD);
    assign slot_free = !slot_held || bus.dc_ready;
    assign push      = slot_held && bus.dc_ready && slot_is_read;
    assign q_empty   = (count_reg == '0);
    assign pop       = bus.dc_rvalid && !q_empty;

    // A read waiting in the slot already owns a tag entry, so it counts
    // against the limit; otherwise a fifth read could slip in behind it.
    assign reserved   = count_reg + CNT_W'(slot_held && slot_is_read);
    assign q_has_room = (reserved < CNT_W'(MAX_OUTSTANDING));

    assign can_issue = slot_free && !flush && !reset;
    assign l0_grant  = can_issue && bus.l0_valid && (!l0_is_read || q_has_room);
    // lane1 never overtakes a valid lane0, even when lane0 is stalled.
    assign l1_grant  = can_issue && !bus.l0_valid && bus.l1_valid &&
                       (!l1_is_read || q_has_room);

    always_comb begin
        state_next     = state_reg;
        slot_next      = slot_reg;
        slot_lane_next = slot_lane_reg;
        if (l0_grant) begin
            state_next     = SLOT_HELD;
            slot_next      = l0_req;
            slot_lane_next = 1'b0;
        end else if (l1_grant) begin
            state_next     = SLOT_HELD;
            slot_next      = l1_req;
            slot_lane_next = 1'b1;
        end else if (slot_free || flush) begin
            state_next = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SLOT_EMPTY;
            slot_reg      <= '0;
            slot_lane_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            slot_lane_reg <= slot_lane_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Tag entries: a flush marks every live entry killed, and a read that
    // leaves the slot in the flush cycle is born killed.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
            logic lane_reg, killed_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg   <= 1'b0;
                    killed_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    lane_reg   <= slot_lane_reg;
                    killed_reg <= flush;
                end else if (flush) begin
                    killed_reg <= 1'b1;
                end
            end
            assign tag_lane[gi]   = lane_reg;
            assign tag_killed[gi] = killed_reg;
        end
    endgenerate

    assign head_lane = tag_lane[rd_ptr_reg];
    assign deliver   = pop && !tag_killed[rd_ptr_reg] && !reset;

    always_ff @(posedge clk) begin
        if (reset)
            resp_err_reg <= 1'b0;
        else if (bus.dc_rvalid && q_empty)
            resp_err_reg <= 1'b1;
    end

    assign bus.l0_ready  = l0_grant;
    assign bus.l1_ready  = l1_grant;
    assign bus.l0_rvalid = deliver && !head_lane;
    assign bus.l1_rvalid = deliver && head_lane;
    assign bus.l0_rdata  = bus.l0_rvalid ? bus.dc_rdata : 32'h0;
    assign bus.l1_rdata  = bus.l1_rvalid ? bus.dc_rdata : 32'h0;

    assign bus.dc_valid      = slot_held;
    assign bus.dc_op         = slot_reg.op;
    assign bus.dc_addr       = slot_reg.addr;
    assign bus.dc_uncached   = slot_reg.uncached;
    assign bus.dc_awstrb     = slot_reg.awstrb;
    assign bus.dc_wdata      = slot_reg.wdata;
    assign bus.dc_cacop_en   = slot_reg.cacop_en;
    assign bus.dc_cacop_code = slot_reg.cacop_code;
    assign bus.dc_cacop_addr = slot_reg.cacop_addr;
    assign bus.resp_err      = resp_err_reg;
endmodule
